ftc_tok_rx: RTL

//  Clocked receiving end of the self-timed fetch-token channel (4-phase bundled-data send/ack).

---
 rtl/ftc_tok_rx.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ftc_tok_rx.sv
// Receiving end of the 4-phase bundled-data fetch-token channel.
// Synchronises send, captures one packet per handshake into a FIFO, and exposes the head on valid/ready.
module ftc_tok_rx #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     send_i,
  output logic                     ack_o,
  input  logic [15:0]              node_i,
  input  logic [11:0]              gen_i,
  input  logic [31:0]              opr0_i,
  input  logic [31:0]              opr1_i,
  input  logic                     mem_wen_i,
  input  logic [33:0]              ins_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [15:0]              node_o,
  output logic [11:0]              gen_o,
  output logic [31:0]              opr0_o,
  output logic [31:0]              opr1_o,
  output logic                     mem_wen_o,
  output logic [33:0]              ins_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, CAPT, HOLD} state_e;

  typedef struct packed {
    logic [15:0] node;
    logic [11:0] gen;
    logic [31:0] opr0;
    logic [31:0] opr1;
    logic        mem_wen;
    logic [33:0] ins;
  } pkt_t;

  state_e                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   valid_q, valid_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  pkt_t                   head_q, head_d;
  pkt_t                   mem [DEPTH];
  pkt_t                   pkt_in;
  logic                   send_s, pop, space, push;

  assign pkt_in = '{node: node_i, gen: gen_i, opr0: opr0_i, opr1: opr1_i,
                    mem_wen: mem_wen_i, ins: ins_i};
  assign send_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    sync_d  = {sync_q[SYNC_STAGES-2:0], send_i};
    pop     = valid_q && ready_i;
    space   = (count_q < CW'(DEPTH)) || pop;
    push    = (state_q == IDLE) && send_s && space;
    state_d = state_q;
    ack_d   = ack_q;
    unique case (state_q)
      IDLE: if (push) state_d = CAPT;
      CAPT: begin
        state_d = HOLD;
        ack_d   = 1'b1;
      end
      HOLD: if (!send_s) begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    valid_d  = (count_d != '0);

    // The new head is the incoming packet when it lands in the slot the read pointer moves to.
    head_d = head_q;
    if (count_d != '0)
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? pkt_in : mem[rd_ptr_d];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      sync_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      sync_q   <= sync_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // NOTE: storage is not reset; occupancy and pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= pkt_in;
  end

  assign ack_o     = ack_q;
  assign valid_o   = valid_q;
  assign count_o   = count_q;
  assign node_o    = head_q.node;
  assign gen_o     = head_q.gen;
  assign opr0_o    = head_q.opr0;
  assign opr1_o    = head_q.opr1;
  assign mem_wen_o = head_q.mem_wen;
  assign ins_o     = head_q.ins;

endmodule
